// File: rtl/sample_stream_pkg.sv
// rtl/sample_stream_pkg.sv - shared types and default sizes for the sample stream reader
// Contents: state_t FSM encoding, default DW/AW/FIFO_DEPTH, fifo_entry_t (tag + sample).
package sample_stream_pkg;

    localparam int SS_DW         = 16;
    localparam int SS_AW         = 16;
    localparam int SS_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    typedef struct packed {
        logic             last;
        logic [SS_DW-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/sample_stream_reader_fifo.sv
// rtl/sample_stream_reader_fifo.sv - small synchronous FIFO with head read from storage
// Ports: clk, reset_n (async active-low), push/wdata (write), pop (read, ignored when empty),
//        rdata (head entry), valid (not empty), count (occupancy 0..DEPTH).
module sample_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_pop;
    logic          full;

    assign valid  = (count != '0);
    assign full   = (count == (PW+1)'(DEPTH));
    assign do_pop = pop && valid;
    assign rdata  = mem[rd_ptr];

    // Storage is cleared on reset so the head reads as zero while empty after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // Push while full is only legal when the head leaves in the same cycle.
    overflow_check: assert property (@(posedge clk) disable iff (!reset_n) !(push && full && !do_pop));

endmodule

// File: rtl/sample_stream_reader.sv
// rtl/sample_stream_reader.sv - walks the sample RAM via the address counter and streams samples out
// Ports: clk, reset_n (async active-low); start_i; addr_i / addr_clr_o / addr_adv_o (address counter);
//        mem_rd_o / mem_addr_o / mem_data_i (RAM, data one cycle after read);
//        sample_o / sample_valid_o / sample_ready_i / last_o (output stream); busy_o; done_o.
// Option: SAMPLE_STREAM_UNDERRUN_EN adds underrun_cnt_o[15:0].
module sample_stream_reader
    import sample_stream_pkg::*;
#(
    parameter int              DW         = SS_DW,
    parameter int              AW         = SS_AW,
    parameter int              FIFO_DEPTH = SS_FIFO_DEPTH,
    parameter logic [AW-1:0]   LAST_ADDR  = '1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start_i,
    input  logic [AW-1:0] addr_i,
    output logic          addr_clr_o,
    output logic          addr_adv_o,
    output logic          mem_rd_o,
    output logic [AW-1:0] mem_addr_o,
    input  logic [DW-1:0] mem_data_i,
    output logic [DW-1:0] sample_o,
    output logic          sample_valid_o,
    input  logic          sample_ready_i,
    output logic          last_o,
    output logic          busy_o,
`ifdef SAMPLE_STREAM_UNDERRUN_EN
    output logic [15:0]   underrun_cnt_o,
`endif
    output logic          done_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q;
    state_t        state_d;
    logic          rd_q;       // a read issued last cycle; its data is on mem_data_i now
    logic          rd_last_q;  // that read was for LAST_ADDR
    logic          done_q;
    logic          issue;
    logic          finish;
    logic          xfer;
    logic          head_last;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] pending;
    logic [DW:0]   head;

    // Credits: every entry held or in flight reserves a FIFO slot, so backpressure never loses data.
    assign pending    = fifo_count + CW'(rd_q);
    assign xfer       = sample_valid_o && sample_ready_i;
    assign head_last  = head[DW];
    assign sample_o   = head[DW-1:0];
    assign last_o     = sample_valid_o && head_last;
    assign finish     = (state_q == DRAIN) && xfer && head_last;
    assign mem_rd_o   = issue;
    assign addr_adv_o = issue;
    assign mem_addr_o = addr_i;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;

    always_comb begin
        state_d    = state_q;
        addr_clr_o = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_clr_o = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (pending < CW'(FIFO_DEPTH)) begin
                    issue = 1'b1;
                    if (addr_i == LAST_ADDR) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (finish) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rd_q      <= 1'b0;
            rd_last_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= issue;
            rd_last_q <= issue && (addr_i == LAST_ADDR);
            done_q    <= finish;
        end
    end

    sample_fifo #(
        .W     (DW + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (rd_q),
        .wdata   ({rd_last_q, mem_data_i}),
        .pop     (sample_ready_i),
        .rdata   (head),
        .valid   (sample_valid_o),
        .count   (fifo_count)
    );

`ifdef SAMPLE_STREAM_UNDERRUN_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt_o <= '0;
        end else if (state_q == IDLE && start_i) begin
            underrun_cnt_o <= '0;
        end else if (state_q != IDLE && sample_ready_i && !sample_valid_o &&
                     underrun_cnt_o != 16'hFFFF) begin
            underrun_cnt_o <= underrun_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sample_stream_reader.sv
// tb/tb_sample_stream_reader.sv - self-checking bench for sample_stream_reader
module tb_sample_stream_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start [3];
    logic        ready [3];
    logic        clr   [3];
    logic        adv   [3];
    logic        rd    [3];
    logic        valid [3];
    logic        lst   [3];
    logic        busy  [3];
    logic        done  [3];
    logic [15:0] addr  [3];
    logic [15:0] maddr [3];
    logic [15:0] mdata [3];
    logic [15:0] smp   [3];
`ifdef SAMPLE_STREAM_UNDERRUN_EN
    logic [15:0] ucnt  [3];
`endif

    int total = 0;
    int bad   = 0;
    int nxt[3], reads[3], xfers[3], max_out[3], passes[3];

    always #5 clk = ~clk;

    // Instance 0: LAST_ADDR=7, instance 1: full 64K pass, instance 2: LAST_ADDR=0.
    function automatic int last_of(int k);
        return (k == 0) ? 7 : ((k == 1) ? 65535 : 0);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sample_stream_reader #(.LAST_ADDR(16'(last_of(g)))) u_dut (
            .clk            (clk),
            .reset_n        (reset_n),
            .start_i        (start[g]),
            .addr_i         (addr[g]),
            .addr_clr_o     (clr[g]),
            .addr_adv_o     (adv[g]),
            .mem_rd_o       (rd[g]),
            .mem_addr_o     (maddr[g]),
            .mem_data_i     (mdata[g]),
            .sample_o       (smp[g]),
            .sample_valid_o (valid[g]),
            .sample_ready_i (ready[g]),
            .last_o         (lst[g]),
            .busy_o         (busy[g]),
`ifdef SAMPLE_STREAM_UNDERRUN_EN
            .underrun_cnt_o (ucnt[g]),
`endif
            .done_o         (done[g])
        );
    end

    // Neighbour models: address counter and sample RAM (garbage on non-read cycles).
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (clr[k])      addr[k] <= 16'd0;
            else if (adv[k]) addr[k] <= addr[k] + 16'd1;
            mdata[k] <= rd[k] ? (maddr[k] ^ 16'hA5A5) : 16'($urandom);
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: a pass reads addresses 0..LAST in order and streams addr^A5A5 in order,
    // at most FIFO_DEPTH samples outstanding, last tag only on LAST, done after LAST+1 transfers.
    task automatic monitor_loop();
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!reset_n) begin
                    nxt[k] = 0; reads[k] = 0; xfers[k] = 0; max_out[k] = 0;
                end else begin
                    if (clr[k]) begin
                        chk("clr_only_idle", busy[k], 0);
                        nxt[k] = 0; reads[k] = 0; xfers[k] = 0; max_out[k] = 0;
                    end
                    if (rd[k] || adv[k]) chk("adv_eq_rd", adv[k], rd[k]);
                    if (rd[k]) begin
                        chk("rd_addr", maddr[k], reads[k] & 32'hFFFF);
                        chk("rd_past_last", reads[k] <= last_of(k), 1);
                        reads[k]++;
                    end
                    if (valid[k] && ready[k]) begin
                        chk("sample", smp[k], (nxt[k] & 32'hFFFF) ^ 32'hA5A5);
                        chk("last_tag", lst[k], nxt[k] == last_of(k));
                        nxt[k]++;
                        xfers[k]++;
                    end
                    if (reads[k] - xfers[k] > max_out[k]) max_out[k] = reads[k] - xfers[k];
                    if (done[k]) begin
                        chk("done_count", xfers[k], last_of(k) + 1);
                        passes[k]++;
                    end
                end
            end
        end
    endtask

    task automatic wait_done(int k, int budget);
        int n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done[k], 1);
    endtask

    task automatic chk_zero(int k, string tag);
        chk({tag, "_busy"}, busy[k], 0);
        chk({tag, "_valid"}, valid[k], 0);
        chk({tag, "_rd"}, rd[k], 0);
        chk({tag, "_clr"}, clr[k], 0);
        chk({tag, "_done"}, done[k], 0);
        chk({tag, "_last"}, lst[k], 0);
        chk({tag, "_sample"}, smp[k], 0);
    endtask

    typedef struct {
        logic        start, ready;
        logic        clr, rd, valid;
        logic [15:0] sample;
        logic        last, done, busy;
    } vec_t;

    vec_t tv [13];

    initial begin
        int n, guard, runs2;
        tv[0]  = '{1, 1, 1, 0, 0, 16'h0000, 0, 0, 0};
        tv[1]  = '{0, 1, 0, 1, 0, 16'h0000, 0, 0, 1};
        tv[2]  = '{0, 1, 0, 1, 0, 16'h0000, 0, 0, 1};
        tv[3]  = '{0, 1, 0, 1, 1, 16'hA5A5, 0, 0, 1};
        tv[4]  = '{0, 1, 0, 1, 1, 16'hA5A4, 0, 0, 1};
        tv[5]  = '{0, 1, 0, 1, 1, 16'hA5A7, 0, 0, 1};
        tv[6]  = '{0, 1, 0, 1, 1, 16'hA5A6, 0, 0, 1};
        tv[7]  = '{0, 1, 0, 1, 1, 16'hA5A1, 0, 0, 1};
        tv[8]  = '{0, 1, 0, 1, 1, 16'hA5A0, 0, 0, 1};
        tv[9]  = '{0, 1, 0, 0, 1, 16'hA5A3, 0, 0, 1};
        tv[10] = '{0, 1, 0, 0, 1, 16'hA5A2, 1, 0, 1};
        tv[11] = '{0, 1, 0, 0, 0, 16'h0000, 0, 1, 0};
        tv[12] = '{0, 1, 0, 0, 0, 16'h0000, 0, 0, 0};

        reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0; ready[k] = 1'b0; passes[k] = 0;
        end
        fork monitor_loop(); join_none

        // Reset state, then idle with start low.
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) chk_zero(k, "reset");
        reset_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk("idle_no_rd", rd[k], 0);
                chk("idle_busy", busy[k], 0);
            end
        end

        // Cycle-exact pass, LAST_ADDR=7, ready held high.
        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            start[0] = tv[i].start;
            ready[0] = tv[i].ready;
            @(negedge clk);
            chk($sformatf("t2_clr[%0d]", i), clr[0], tv[i].clr);
            chk($sformatf("t2_rd[%0d]", i), rd[0], tv[i].rd);
            chk($sformatf("t2_valid[%0d]", i), valid[0], tv[i].valid);
            if (tv[i].valid) chk($sformatf("t2_sample[%0d]", i), smp[0], tv[i].sample);
            chk($sformatf("t2_last[%0d]", i), lst[0], tv[i].last);
            chk($sformatf("t2_done[%0d]", i), done[0], tv[i].done);
            chk($sformatf("t2_busy[%0d]", i), busy[0], tv[i].busy);
        end
`ifdef SAMPLE_STREAM_UNDERRUN_EN
        chk("t6_underrun", ucnt[0], 2);
`endif

        // Backpressure: ready low for 10 cycles after first valid, start held (must be ignored).
        @(posedge clk); #1;
        start[0] = 1'b1; ready[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid[0] && n < 20);
        chk("t3_first_valid", valid[0], 1);
        repeat (9) @(negedge clk);
        chk("t3_rd_stalled", rd[0], 0);
        chk("t3_credit_max", max_out[0], 4);
        @(posedge clk); #1;
        ready[0] = 1'b1; start[0] = 1'b0;
        wait_done(0, 50);

        // Reset after the 3rd transfer, then restart from address 0.
        @(posedge clk); #1;
        start[0] = 1'b1; ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0; guard = 0;
        while (n < 3 && guard < 30) begin
            @(negedge clk);
            if (valid[0] && ready[0]) n++;
            guard++;
        end
        chk("t5_three_xfers", n, 3);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk_zero(0, "t5_rst");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!valid[0] && n < 20);
        chk("t5_restart_valid", valid[0], 1);
        chk("t5_restart_sample", smp[0], 16'hA5A5);
        wait_done(0, 50);

        // Randomized ready and stray start pulses, LAST_ADDR=7 and LAST_ADDR=0.
        runs2 = 0;
        for (int p = 0; p < 8; p++) begin
            int k;
            k = (p % 2 == 0) ? 0 : 2;
            if (k == 2) runs2++;
            @(posedge clk); #1;
            start[k] = 1'b1;
            ready[k] = 1'($urandom_range(0, 1));
            guard = 0;
            do begin
                @(posedge clk); #1;
                ready[k] = 1'($urandom_range(0, 1));
                start[k] = busy[k] ? 1'($urandom_range(0, 1)) : 1'b0;
                @(negedge clk);
                guard++;
            end while (!done[k] && guard < 200);
            chk("rand_done", done[k], 1);
            @(posedge clk); #1;
            start[k] = 1'b0;
        end
        chk("rand_passes_last0", passes[2], runs2);

        // Full 64K pass.
        @(posedge clk); #1;
        start[1] = 1'b1; ready[1] = 1'b1;
        @(posedge clk); #1;
        start[1] = 1'b0;
        wait_done(1, 70000);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t4_no_rd_after", rd[1], 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
